sprite_anim_sequencer: RTL and testbench

SPRITE_ANIM_SEQUENCER -- requirements
Module: sprite_anim_sequencer

---
 rtl/sprite_pkg.sv | 42 ++++
 rtl/sprite_addr_pipe.sv | 74 +++++++
 rtl/sprite_anim_sequencer.sv | 125 ++++++++++++
 tb/tb_sprite_anim_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and per-pose tables for the sprite animation sequencer.
// POSE_BASE places each pose's frames back to back in the sprite ROM.
package sprite_pkg;

  localparam int NUM_POSES  = 6;
  localparam int MAX_FRAMES = 4;
  localparam int FRAME_W    = 64;
  localparam int FRAME_H    = 96;
  localparam int FRAME_SIZE = FRAME_W * FRAME_H;

  typedef enum logic [2:0] {
    POSE_STAND  = 3'd0,
    POSE_PUNCH  = 3'd1,
    POSE_JUMP   = 3'd2,
    POSE_CROUCH = 3'd3,
    POSE_WALK_L = 3'd4,
    POSE_WALK_R = 3'd5
  } pose_e;

  typedef enum logic [1:0] {
    ST_LOOP,
    ST_ONESHOT,
    ST_HOLD
  } state_e;

  localparam int FRAME_COUNT [NUM_POSES] = '{1, 3, 4, 1, 4, 4};

  localparam logic [31:0] POSE_BASE [NUM_POSES] = '{
    32'(0),
    32'(1 * FRAME_SIZE),
    32'(4 * FRAME_SIZE),
    32'(8 * FRAME_SIZE),
    32'(9 * FRAME_SIZE),
    32'(13 * FRAME_SIZE)
  };

  // Punch and jump play once and then fall back to standing.
  function automatic logic is_oneshot(input logic [2:0] pose);
    return (pose == POSE_PUNCH) || (pose == POSE_JUMP);
  endfunction

endpackage

// File: rtl/sprite_addr_pipe.sv
// Per-pixel sprite ROM address generation with horizontal mirroring, and the
// 3-stage pipeline that turns returned palette indices into pixel_idx/sprite_on.
module sprite_addr_pipe
  import sprite_pkg::*;
#(
  parameter int FRAME_W    = 64,
  parameter int FRAME_H    = 96,
  parameter int ADDR_W     = 16,
  parameter int FRAME_BITS = 2
) (
  input  logic                  vga_clk,
  input  logic                  reset,
  input  logic [2:0]            pose,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  mirror,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic [9:0]            PosX,
  input  logic [9:0]            PosY,
  input  logic                  blank,
  input  logic [3:0]            rom_data,
  output logic [ADDR_W-1:0]     rom_addr,
  output logic [3:0]            pixel_idx,
  output logic                  sprite_on
);

  logic              x_in, y_in, in_box;
  logic [9:0]        dx, dy;
  logic [31:0]       col;
  logic [ADDR_W-1:0] addr_next;
  logic              in_box_d1, in_box_d2;
  logic              blank_d1, blank_d2;
  logic              pix_hit;

  always_comb begin
    // Widen to 11 bits so a box near the right/bottom edge never wraps to 0.
    x_in   = ({1'b0, DrawX} >= {1'b0, PosX}) &&
             ({1'b0, DrawX} <  ({1'b0, PosX} + 11'(FRAME_W)));
    y_in   = ({1'b0, DrawY} >= {1'b0, PosY}) &&
             ({1'b0, DrawY} <  ({1'b0, PosY} + 11'(FRAME_H)));
    in_box = x_in && y_in;
    dx     = DrawX - PosX;
    dy     = DrawY - PosY;
    col    = mirror ? (32'(FRAME_W - 1) - 32'(dx)) : 32'(dx);
    addr_next = ADDR_W'(POSE_BASE[pose])
              + ADDR_W'(32'(frame) * 32'(FRAME_W * FRAME_H))
              + ADDR_W'(32'(dy) * 32'(FRAME_W))
              + ADDR_W'(col);
    pix_hit = in_box_d2 && blank_d2 && (rom_data != 4'd0);
  end

  // NOTE: registers use non-blocking assignments so every stage samples the
  // previous stage's value from before the edge, giving a true pipeline.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_addr  <= '0;
      in_box_d1 <= 1'b0;
      in_box_d2 <= 1'b0;
      blank_d1  <= 1'b0;
      blank_d2  <= 1'b0;
      pixel_idx <= 4'd0;
      sprite_on <= 1'b0;
    end else begin
      rom_addr  <= in_box ? addr_next : '0;
      in_box_d1 <= in_box;
      blank_d1  <= blank;
      in_box_d2 <= in_box_d1;
      blank_d2  <= blank_d1;
      sprite_on <= pix_hit;
      pixel_idx <= pix_hit ? rom_data : 4'd0;
    end
  end

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Character sprite animation: pose/frame sequencing on video-frame ticks
// (loop, one-shot, hold) feeding the per-pixel sprite ROM address pipeline.
module sprite_anim_sequencer
  import sprite_pkg::*;
#(
  parameter int NUM_POSES       = 6,
  parameter int MAX_FRAMES      = 4,
  parameter int FRAME_W         = 64,
  parameter int FRAME_H         = 96,
  parameter int TICKS_PER_FRAME = 6,
  parameter int ADDR_W          = 16
) (
  input  logic                          vga_clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic [2:0]                    pose_req,
  input  logic                          facing_left,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic [9:0]                    PosX,
  input  logic [9:0]                    PosY,
  input  logic                          blank,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [3:0]                    rom_data,
  output logic [3:0]                    pixel_idx,
  output logic                          sprite_on,
  output logic [2:0]                    pose_cur,
  output logic [$clog2(MAX_FRAMES)-1:0] frame_cur,
  output logic                          busy
);

  localparam int FRAME_BITS = $clog2(MAX_FRAMES);
  localparam int TICK_W     = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

  state_e                state;
  logic [TICK_W-1:0]     tick_cnt;
  logic                  mirror;
  logic [2:0]            pose_sel;
  logic                  tick_wrap;
  logic [FRAME_BITS-1:0] last_frame;

  always_comb begin
    pose_sel   = (int'(pose_req) >= NUM_POSES) ? 3'(POSE_STAND) : pose_req;
    tick_wrap  = (tick_cnt == TICK_W'(TICKS_PER_FRAME - 1));
    last_frame = FRAME_BITS'(FRAME_COUNT[pose_cur] - 1);
  end

  // Reset has priority, so a frame_tick in the same cycle is dropped.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state     <= ST_LOOP;
      pose_cur  <= 3'(POSE_STAND);
      frame_cur <= '0;
      tick_cnt  <= '0;
      mirror    <= 1'b0;
      busy      <= 1'b0;
    end else if (frame_tick) begin
      mirror <= facing_left;
      case (state)
        ST_LOOP: begin
          if (is_oneshot(pose_sel)) begin
            state     <= ST_ONESHOT;
            pose_cur  <= pose_sel;
            frame_cur <= '0;
            tick_cnt  <= '0;
            busy      <= 1'b1;
          end else if (pose_sel != pose_cur) begin
            pose_cur  <= pose_sel;
            frame_cur <= '0;
            tick_cnt  <= '0;
          end else if (tick_wrap) begin
            tick_cnt  <= '0;
            frame_cur <= (frame_cur == last_frame) ? '0 : frame_cur + 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        ST_ONESHOT: begin
          if (tick_wrap) begin
            tick_cnt <= '0;
            if (frame_cur == last_frame) state <= ST_HOLD;
            else frame_cur <= frame_cur + 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (tick_wrap) begin
            state     <= ST_LOOP;
            pose_cur  <= 3'(POSE_STAND);
            frame_cur <= '0;
            tick_cnt  <= '0;
            busy      <= 1'b0;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: state <= ST_LOOP;
      endcase
    end
  end

  sprite_addr_pipe #(
    .FRAME_W    (FRAME_W),
    .FRAME_H    (FRAME_H),
    .ADDR_W     (ADDR_W),
    .FRAME_BITS (FRAME_BITS)
  ) u_addr_pipe (
    .vga_clk   (vga_clk),
    .reset     (reset),
    .pose      (pose_cur),
    .frame     (frame_cur),
    .mirror    (mirror),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .PosX      (PosX),
    .PosY      (PosY),
    .blank     (blank),
    .rom_data  (rom_data),
    .rom_addr  (rom_addr),
    .pixel_idx (pixel_idx),
    .sprite_on (sprite_on)
  );

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Directed bench for sprite_anim_sequencer: pose sequencing, one-shot/hold,
// mirrored addressing, pixel pipeline latency and reset behaviour.
module tb_sprite_anim_sequencer;

  logic        vga_clk = 1'b0;
  logic        reset, frame_tick, facing_left, blank;
  logic [2:0]  pose_req;
  logic [9:0]  DrawX, DrawY, PosX, PosY;
  logic [15:0] rom_addr;
  logic [3:0]  rom_data, rom_val, pixel_idx;
  logic        sprite_on;
  logic [2:0]  pose_cur;
  logic [1:0]  frame_cur;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 vga_clk = ~vga_clk;

  // Synchronous ROM stand-in: data follows the address by one cycle.
  always @(posedge vga_clk) rom_data <= rom_val;

  sprite_anim_sequencer dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .pose_req    (pose_req),
    .facing_left (facing_left),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .PosX        (PosX),
    .PosY        (PosY),
    .blank       (blank),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pixel_idx   (pixel_idx),
    .sprite_on   (sprite_on),
    .pose_cur    (pose_cur),
    .frame_cur   (frame_cur),
    .busy        (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic frame_step();
    @(negedge vga_clk);
    frame_tick = 1'b1;
    @(negedge vga_clk);
    frame_tick = 1'b0;
  endtask

  task automatic check_state(input string tag, input int pose, input int frame, input int bsy);
    check({tag, ".pose"},  int'(pose_cur),  pose);
    check({tag, ".frame"}, int'(frame_cur), frame);
    check({tag, ".busy"},  int'(busy),      bsy);
  endtask

  initial begin
    // Reset with a coincident frame_tick requesting walk-left while mirrored.
    reset = 1'b1; frame_tick = 1'b1; pose_req = 3'd4; facing_left = 1'b1;
    blank = 1'b0; DrawX = 10'd0; DrawY = 10'd0; PosX = 10'd100; PosY = 10'd50;
    rom_val = 4'd0;
    cycles(3);
    frame_tick = 1'b0;
    reset = 1'b0;
    check_state("reset", 0, 0, 0);
    check("reset.rom_addr",  int'(rom_addr),  0);
    check("reset.sprite_on", int'(sprite_on), 0);
    check("reset.pixel_idx", int'(pixel_idx), 0);

    // Unmirrored in-box address: row 2, col 5 of pose 0 frame 0.
    DrawX = 10'd105; DrawY = 10'd52;
    cycles(1);
    check("addr.stand", int'(rom_addr), 133);

    // Walk-left loop: frames 0,1,2,3,0 each held for 6 ticks.
    facing_left = 1'b0;
    pose_req    = 3'd4;
    for (int i = 0; i < 30; i++) begin
      frame_step();
      check_state($sformatf("walk%0d", i), 4, (i / 6) % 4, 0);
      // 55296 + 2*6144 + 133 = 67717, truncated to 16 bits.
      if (i == 13) check("addr.walk_f2", int'(rom_addr), 2181);
    end

    // pose_req changes between ticks take effect only on the next tick.
    pose_req = 3'd3;
    cycles(4);
    check("req_between.pose", int'(pose_cur), 4);
    frame_step();
    check_state("crouch", 3, 0, 0);
    pose_req = 3'd7;
    frame_step();
    check_state("pose7", 0, 0, 0);

    // Walk-right base 79872 + 133 = 80005, truncated to 16 bits.
    pose_req = 3'd5;
    frame_step();
    cycles(1);
    check("addr.walk_r", int'(rom_addr), 14469);
    pose_req = 3'd0;
    frame_step();

    // Punch: 3 frames x 6 ticks, hold 6 ticks, back to stand; crouch ignored.
    pose_req = 3'd1;
    frame_step();
    check_state("punch0", 1, 0, 1);
    pose_req = 3'd3;
    for (int i = 1; i <= 24; i++) begin
      frame_step();
      if (i < 24) check_state($sformatf("punch%0d", i), 1, (i < 18) ? i / 6 : 2, 1);
      else        check_state("punch_done", 0, 0, 0);
    end
    pose_req = 3'd0;
    frame_step();
    check_state("after_punch", 0, 0, 0);

    // Mirrored addressing at the left edge, right edge and one past it.
    facing_left = 1'b1;
    frame_step();
    blank = 1'b1; rom_val = 4'd5;
    DrawY = 10'd52; DrawX = 10'd100;
    cycles(1);
    check("mirror.left_edge", int'(rom_addr), 191);
    DrawX = 10'd163;
    cycles(1);
    check("mirror.right_edge", int'(rom_addr), 128);
    DrawX = 10'd164;
    cycles(1);
    check("mirror.outside_addr", int'(rom_addr), 0);
    cycles(2);
    check("mirror.outside_on", int'(sprite_on), 0);

    // Transparent index 0 inside the box.
    rom_val = 4'd0;
    DrawX = 10'd110;
    cycles(4);
    check("transparent.on",  int'(sprite_on), 0);
    check("transparent.idx", int'(pixel_idx), 0);

    // One-cycle in-box pulse must appear exactly 3 cycles later.
    rom_val = 4'd5;
    DrawX = 10'd0;
    cycles(4);
    DrawX = 10'd110;
    cycles(1);
    DrawX = 10'd0;
    cycles(1);
    check("latency.early", int'(sprite_on), 0);
    cycles(1);
    check("latency.on",  int'(sprite_on), 1);
    check("latency.idx", int'(pixel_idx), 5);
    cycles(1);
    check("latency.late", int'(sprite_on), 0);

    // Outside active video nothing is drawn.
    blank = 1'b0;
    DrawX = 10'd110;
    cycles(4);
    check("blank.on",  int'(sprite_on), 0);
    check("blank.idx", int'(pixel_idx), 0);
    blank = 1'b1;

    // Reset in the middle of a punch (frame 1).
    pose_req = 3'd1;
    frame_step();
    pose_req = 3'd0;
    repeat (6) frame_step();
    check_state("punch_mid", 1, 1, 1);
    check("punch_mid.sprite_on", int'(sprite_on), 1);
    reset = 1'b1;
    cycles(1);
    check_state("mid_reset", 0, 0, 0);
    check("mid_reset.rom_addr",  int'(rom_addr),  0);
    check("mid_reset.sprite_on", int'(sprite_on), 0);
    check("mid_reset.pixel_idx", int'(pixel_idx), 0);
    reset = 1'b0;
    pose_req = 3'd4;
    frame_step();
    check_state("post_reset_loop", 4, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
